// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with a skid buffer.
//
// The main register feeds the output directly; the skid register catches the
// one extra beat that can arrive while the downstream stalls, so in_ready can
// come straight from a flop instead of combinationally from out_ready.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_EMPTY | nothing held; out_data = BUBBLE, in_ready = 1, occ = 0
// ST_ONE   | main holds the oldest entry; skid empty, in_ready = 1, occ = 1
// ST_FULL  | main holds oldest, skid holds next; in_ready = 0, occ = 2
//
// Flush empties both registers. Reset does the same and takes priority
// over flush and over any handshake.

module pipe_skid_reg #(
   parameter int             W      = 32,
   parameter logic [W-1:0]   BUBBLE = W'(32'h0000_0013)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           in_valid,
   input  logic [W-1:0]   in_data,
   output logic           in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   input  logic           out_ready,
   output logic [1:0]     occ
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t         state_q,     state_d;
   logic [W-1:0]   main_data_q, main_data_d;
   logic [W-1:0]   skid_data_q, skid_data_d;
   logic           main_v_q,    main_v_d;
   logic           in_ready_q,  in_ready_d;
   logic [1:0]     occ_q,       occ_d;

   logic           in_fire;
   logic           out_fire;
   logic           skid_v_d;

   // Handshakes use only registered readiness/validity.
   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = main_v_q & out_ready;

   // Next-state and next-data selection; flags follow from the next state.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;

      if (flush) begin
         state_d     = ST_EMPTY;
         main_data_d = BUBBLE;
         skid_data_d = BUBBLE;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d     = ST_ONE;
                  main_data_d = in_data;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_data_d = in_data;
               end else if (in_fire) begin
                  state_d     = ST_FULL;
                  skid_data_d = in_data;
               end else if (out_fire) begin
                  state_d     = ST_EMPTY;
                  main_data_d = BUBBLE;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire) begin
                  state_d     = ST_ONE;
                  main_data_d = skid_data_q;
                  skid_data_d = BUBBLE;
               end
            end
            default: begin
               state_d     = ST_EMPTY;
               main_data_d = BUBBLE;
               skid_data_d = BUBBLE;
            end
         endcase
      end

      main_v_d   = (state_d != ST_EMPTY);
      skid_v_d   = (state_d == ST_FULL);
      in_ready_d = ~skid_v_d;
      occ_d      = {1'b0, main_v_d} + {1'b0, skid_v_d};
   end

   // State, data and registered outputs; synchronous reset wins over everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         main_data_q <= BUBBLE;
         skid_data_q <= BUBBLE;
         main_v_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         occ_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         skid_data_q <= skid_data_d;
         main_v_q    <= main_v_d;
         in_ready_q  <= in_ready_d;
         occ_q       <= occ_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_v_q;
   assign out_data  = main_data_q;
   assign occ       = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed vector table on a 32-bit instance,
// hand-written reset-timing sequence, and queue-model random traffic on
// 8-bit and 64-bit instances.

module tb_pipe_skid_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- 32-bit instance, directed ----------------
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_data;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic [1:0]  occ;

   pipe_skid_reg #(.W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .occ(occ)
   );

   // ---------------- 8-bit and 64-bit instances, random ----------------
   logic        r_rst_n;
   logic        fl8, iv8, or8, ir8, ov8;
   logic [7:0]  id8, od8;
   logic [1:0]  occ8;
   logic        fl64, iv64, or64, ir64, ov64;
   logic [63:0] id64, od64;
   logic [1:0]  occ64;

   pipe_skid_reg #(.W(8), .BUBBLE(8'h13)) dut8 (
      .clk(clk), .rst_n(r_rst_n), .flush(fl8),
      .in_valid(iv8), .in_data(id8), .in_ready(ir8),
      .out_valid(ov8), .out_data(od8), .out_ready(or8),
      .occ(occ8)
   );

   pipe_skid_reg #(.W(64), .BUBBLE(64'h13)) dut64 (
      .clk(clk), .rst_n(r_rst_n), .flush(fl64),
      .in_valid(iv64), .in_data(id64), .in_ready(ir64),
      .out_valid(ov64), .out_data(od64), .out_ready(or64),
      .occ(occ64)
   );

   typedef struct {
      logic        rst_n;
      logic        flush;
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic        ov;
      logic [31:0] od;
      logic [1:0]  occ;
      logic        ir;
   } vec_t;

   localparam int NV = 25;
   vec_t tbl [NV];

   function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] id, logic ordy,
                               logic ov, logic [31:0] od, logic [1:0] oc, logic ir);
      vec_t v;
      v.rst_n = r;  v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
      v.ov = ov;    v.od = od;   v.occ = oc; v.ir = ir;
      return v;
   endfunction

   task automatic chk32(input string tag, input logic ov, input logic [31:0] od,
                        input logic [1:0] oc, input logic ir);
      chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ov});
      chk({tag, ".out_data"},  {32'd0, out_data},  {32'd0, od});
      chk({tag, ".occ"},       {62'd0, occ},       {62'd0, oc});
      chk({tag, ".in_ready"},  {63'd0, in_ready},  {63'd0, ir});
   endtask

   logic [7:0]  q8  [$];
   logic [63:0] q64 [$];

   initial begin
      //            rst flu iv  in_data      ordy | ov  out_data     occ ir
      tbl[0]  = mk(0, 0, 0, 32'h0,        1,     0, 32'h13,      0,  1); // reset
      tbl[1]  = mk(1, 0, 1, 32'h11,       1,     1, 32'h11,      1,  1); // streaming
      tbl[2]  = mk(1, 0, 1, 32'h22,       1,     1, 32'h22,      1,  1);
      tbl[3]  = mk(1, 0, 1, 32'h33,       1,     1, 32'h33,      1,  1);
      tbl[4]  = mk(1, 0, 0, 32'h0,        1,     0, 32'h13,      0,  1);
      tbl[5]  = mk(1, 0, 1, 32'hA1,       0,     1, 32'hA1,      1,  1); // fill to FULL
      tbl[6]  = mk(1, 0, 1, 32'hA2,       0,     1, 32'hA1,      2,  0);
      tbl[7]  = mk(1, 0, 1, 32'hA3,       0,     1, 32'hA1,      2,  0); // refused
      tbl[8]  = mk(1, 0, 1, 32'hA3,       1,     1, 32'hA2,      1,  1); // skid -> main
      tbl[9]  = mk(1, 0, 1, 32'hA3,       1,     1, 32'hA3,      1,  1);
      tbl[10] = mk(1, 0, 0, 32'h0,        1,     0, 32'h13,      0,  1);
      tbl[11] = mk(1, 0, 1, 32'hC1,       0,     1, 32'hC1,      1,  1); // stall hold
      tbl[12] = mk(1, 0, 0, 32'h0,        0,     1, 32'hC1,      1,  1);
      tbl[13] = mk(1, 0, 0, 32'h0,        1,     0, 32'h13,      0,  1);
      tbl[14] = mk(1, 0, 1, 32'hB1,       0,     1, 32'hB1,      1,  1); // flush in FULL
      tbl[15] = mk(1, 0, 1, 32'hB2,       0,     1, 32'hB1,      2,  0);
      tbl[16] = mk(1, 1, 1, 32'hB3,       0,     0, 32'h13,      0,  1);
      tbl[17] = mk(1, 0, 1, 32'hD1,       0,     1, 32'hD1,      1,  1); // flush with both fires
      tbl[18] = mk(1, 1, 1, 32'hD2,       1,     0, 32'h13,      0,  1);
      tbl[19] = mk(1, 0, 0, 32'h0,        1,     0, 32'h13,      0,  1);
      tbl[20] = mk(1, 0, 1, 32'hE1,       0,     1, 32'hE1,      1,  1); // reset+flush in FULL
      tbl[21] = mk(1, 0, 1, 32'hE2,       0,     1, 32'hE1,      2,  0);
      tbl[22] = mk(0, 1, 1, 32'hE3,       1,     0, 32'h13,      0,  1);
      tbl[23] = mk(0, 0, 1, 32'hE4,       1,     0, 32'h13,      0,  1);
      tbl[24] = mk(1, 0, 0, 32'h0,        1,     0, 32'h13,      0,  1);

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      r_rst_n = 1'b0;
      fl8 = 1'b0; iv8 = 1'b0; or8 = 1'b0; id8 = '0;
      fl64 = 1'b0; iv64 = 1'b0; or64 = 1'b0; id64 = '0;

      // Directed table.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst_n = tbl[i].rst_n; flush = tbl[i].flush; in_valid = tbl[i].iv;
         in_data = tbl[i].id; out_ready = tbl[i].ordy;
         @(posedge clk);
         #1;
         chk32($sformatf("v%0d", i), tbl[i].ov, tbl[i].od, tbl[i].occ, tbl[i].ir);
      end

      // Reset changes only at an edge, never between edges.
      @(negedge clk);
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hF1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_data = 32'hF2;
      @(posedge clk);
      #1;
      chk32("full_before_rst", 1'b1, 32'hF1, 2'd2, 1'b0);
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk32("rst_between_edges", 1'b1, 32'hF1, 2'd2, 1'b0);
      @(posedge clk);
      #1;
      chk32("rst_at_edge", 1'b0, 32'h13, 2'd0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b1; in_data = 32'hF3; out_ready = 1'b0;
      #1;
      chk32("rst_release_between_edges", 1'b0, 32'h13, 2'd0, 1'b1);
      @(posedge clk);
      #1;
      chk32("first_after_release", 1'b1, 32'hF3, 2'd1, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;

      // Random traffic against a queue model on W=8 and W=64.
      r_rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      r_rst_n = 1'b1;
      q8.delete();
      q64.delete();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         bit m8_in, m8_out, m64_in, m64_out;
         logic [7:0]  e8;
         logic [63:0] e64;
         @(negedge clk);
         iv8  = 1'($urandom_range(0, 1));
         or8  = 1'($urandom_range(0, 1));
         id8  = 8'($urandom);
         fl8  = ($urandom_range(0, 63) == 0);
         iv64 = 1'($urandom_range(0, 1));
         or64 = 1'($urandom_range(0, 1));
         id64 = {$urandom, $urandom};
         fl64 = ($urandom_range(0, 63) == 0);
         m8_in   = iv8  && (q8.size()  < 2);
         m8_out  = or8  && (q8.size()  > 0);
         m64_in  = iv64 && (q64.size() < 2);
         m64_out = or64 && (q64.size() > 0);
         @(posedge clk);
         if (fl8) q8.delete();
         else begin
            if (m8_out) void'(q8.pop_front());
            if (m8_in)  q8.push_back(id8);
         end
         if (fl64) q64.delete();
         else begin
            if (m64_out) void'(q64.pop_front());
            if (m64_in)  q64.push_back(id64);
         end
         #1;
         e8  = (q8.size()  > 0) ? q8[0]  : 8'h13;
         e64 = (q64.size() > 0) ? q64[0] : 64'h13;
         chk("w8.out_valid",  {63'd0, ov8},  {63'd0, 1'(q8.size() > 0)});
         chk("w8.out_data",   {56'd0, od8},  {56'd0, e8});
         chk("w8.occ",        {62'd0, occ8}, 64'(q8.size()));
         chk("w8.in_ready",   {63'd0, ir8},  {63'd0, 1'(q8.size() < 2)});
         chk("w64.out_valid", {63'd0, ov64}, {63'd0, 1'(q64.size() > 0)});
         chk("w64.out_data",  od64,          e64);
         chk("w64.occ",       {62'd0, occ64}, 64'(q64.size()));
         chk("w64.in_ready",  {63'd0, ir64}, {63'd0, 1'(q64.size() < 2)});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001: Parameter W, default 32, data width in bits (W >= 1).
REQ-002: Parameter BUBBLE, W bits, default 32'h0000_0013 (NOP), value presented on out_data and loaded into data registers whenever no entry is valid.
REQ-003: clk  input  1  single clock; all state updates on posedge clk.
REQ-004: rst_n  input  1  reset, synchronous, active-low, sampled on posedge clk.
REQ-005: flush  input  1  discard all held entries (bubble insertion).
REQ-006: in_valid  input  1  upstream offers in_data.
REQ-007: in_data  input  W  upstream payload.
REQ-008: in_ready  output  1  block can accept; accept ("in_fire") = in_valid & in_ready.
REQ-009: out_valid  output  1  out_data holds a valid entry.
REQ-010: out_data  output  W  payload of oldest entry; BUBBLE when out_valid=0.
REQ-011: out_ready  input  1  downstream consumes; consume ("out_fire") = out_valid & out_ready.
REQ-012: occ  output  2  current occupancy: 0, 1 or 2 entries.

Function
REQ-013: Storage SHALL be a main register (main_v, main_d) and a skid register (skid_v, skid_d); state EMPTY (occ=0), ONE (main only, occ=1), FULL (main+skid, occ=2); skid_v=1 with main_v=0 SHALL never occur.
REQ-014: in_ready SHALL equal ~skid_v, driven directly from a register, with no combinational path from out_ready or flush.
REQ-015: out_valid SHALL equal main_v and out_data SHALL equal main_d; both SHALL be register outputs.
REQ-016: Latency SHALL be one cycle: data accepted at edge N appears on out_data after edge N when it becomes the oldest entry.
REQ-017: EMPTY: in_fire -> ONE, main_d <= in_data; otherwise stay.
REQ-018: ONE: in_fire & out_fire -> ONE, main_d <= in_data (full throughput, one transfer per cycle); in_fire only -> FULL, skid_d <= in_data; out_fire only -> EMPTY, main_d <= BUBBLE; neither -> hold.
REQ-019: FULL: in_ready=0, so no in_fire; out_fire -> ONE, main_d <= skid_d, skid_d <= BUBBLE; otherwise hold.
REQ-020: Ordering SHALL be strict FIFO; no entry SHALL be duplicated or dropped except by flush or reset.
REQ-021: flush=1 at an edge (rst_n=1) SHALL force EMPTY: main_v=skid_v=0, main_d=skid_d=BUBBLE, regardless of in_fire/out_fire in that cycle; an in_fire in a flush cycle SHALL be discarded (upstream sees it as accepted).
REQ-022: An out_fire in a flush cycle SHALL count as delivered downstream; the block takes no further action for it.
REQ-023: occ SHALL equal main_v + skid_v, registered, consistent with REQ-013.
REQ-024: Data registers SHALL hold value when not written (stall); out_data SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-025: rst_n=0 at an edge SHALL force EMPTY: main_v=skid_v=0, main_d=skid_d=BUBBLE, occ=0, in_ready=1, out_valid=0, out_data=BUBBLE.
REQ-026: Reset SHALL take priority over flush and all handshakes, including mid-transfer in FULL.
REQ-027: No state change SHALL occur between edges; rst_n deasserting between edges has no effect until the next edge.

Verification
REQ-028: Reset, then in_valid=1 with in_data=0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 on cycles 1,2,3, in_ready always 1, occ=1.
REQ-029: out_ready=0, push 0xA1 then 0xA2 -> occ=2, in_ready=0, out_data=0xA1; third offer 0xA3 not accepted; out_ready=1 for 2 cycles -> 0xA1 then 0xA2, then 0xA3 accepted and delivered.
REQ-030: FULL (0xB1,0xB2) with flush=1 and in_valid=1 (0xB3) -> next cycle occ=0, out_valid=0, out_data=BUBBLE (0x00000013), in_ready=1; 0xB3 never appears.
REQ-031: FULL with rst_n=0 and flush=1 on the same edge -> reset state per REQ-025; with rst_n=0 held, in_valid=1 has no effect.
REQ-032: Random in_valid/out_ready (50%) for 10k cycles with W=8 and W=64 -> scoreboard order match, no loss/duplication, occ always equals accepted-minus-delivered, out_data stable while stalled.
